// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: shifts ALU result bytes out as UART frames
// (start, 8 data bits LSB first, optional even parity, stop) on one pin.
//
// Handshake: a byte transfers on a rising edge where res_valid && res_ready.
// res_ready is registered and high only in IDLE. res_data/res_valid are
// ignored while res_ready is low, and the byte is held internally once
// accepted. res_valid may drop without a transfer.
module alu_result_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] res_data,
    input  logic       res_valid,
    output logic       res_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent,
    output logic [2:0] state
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              parity;
    logic              baud_done;

    // Terminal count of the per-bit cycle counter.
    assign baud_done = (baud_cnt == BAUD_LAST);

    // Frame sequencer. tx, res_ready and busy are registered alongside
    // the state so each takes its new value on the same edge the state
    // changes; every counter clears on a state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tx          <= 1'b1;
            res_ready   <= 1'b1;
            busy        <= 1'b0;
            frames_sent <= 8'd0;
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'd0;
            parity      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (res_valid && res_ready) begin
                        shreg     <= res_data;
                        parity    <= ^res_data;
                        state     <= S_START;
                        tx        <= 1'b0;
                        res_ready <= 1'b0;
                        busy      <= 1'b1;
                        baud_cnt  <= '0;
                        bit_idx   <= 3'd0;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        state    <= S_DATA;
                        tx       <= shreg[0];
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            if (PARITY_EN) begin
                                state <= S_PARITY;
                                tx    <= parity;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baud_done) begin
                        state    <= S_STOP;
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        state       <= S_IDLE;
                        tx          <= 1'b1;
                        res_ready   <= 1'b1;
                        busy        <= 1'b0;
                        frames_sent <= frames_sent + 8'd1;
                        baud_cnt    <= '0;
                        bit_idx     <= 3'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    tx        <= 1'b1;
                    res_ready <= 1'b1;
                    busy      <= 1'b0;
                    baud_cnt  <= '0;
                    bit_idx   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: two instances at 4 clocks per bit, one
// without and one with even parity, checked every cycle against a
// frame-level model, plus hand-computed frame decodes.
module tb_alu_result_uart_tx;

    localparam int N = 4;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic [7:0] data0 = 8'd0, data1 = 8'd0;
    logic       ready0, ready1, tx0, tx1, busy0, busy1;
    logic [7:0] frames0, frames1;
    logic [2:0] state0, state1;

    alu_result_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .res_data(data0), .res_valid(valid0),
        .res_ready(ready0), .tx(tx0), .busy(busy0),
        .frames_sent(frames0), .state(state0)
    );

    alu_result_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .res_data(data1), .res_valid(valid1),
        .res_ready(ready1), .tx(tx1), .busy(busy1),
        .frames_sent(frames1), .state(state1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame model: bit idx of the frame for byte b (0 start, 1..8 data LSB
    // first, 9 parity when enabled, last one stop).
    function automatic logic frame_bit(input logic [7:0] b, input int idx, input bit pen);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && pen) return ^b;
        return 1'b1;
    endfunction

    // One clock of the model: an idle transmitter accepts a valid byte,
    // a busy one spends F*N cycles on the frame then counts it.
    task automatic model_step(input logic v, input logic [7:0] d, input int f,
                              inout bit act, inout int pos, inout logic [7:0] byt,
                              inout logic [7:0] fr, output bit acc);
        acc = 1'b0;
        if (!act) begin
            if (v) begin
                act = 1'b1; pos = 0; byt = d; acc = 1'b1;
            end
        end else begin
            pos++;
            if (pos == f * N) begin
                act = 1'b0;
                fr  = fr + 8'd1;
            end
        end
    endtask

    bit         m_act0, m_act1;
    int         m_pos0, m_pos1;
    logic [7:0] m_byte0, m_byte1, m_fr0, m_fr1;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    // Scoreboard model update on each active edge
    always @(posedge clk or posedge rst) begin
        bit acc;
        if (rst) begin
            m_act0 = 1'b0; m_pos0 = 0; m_fr0 = 8'd0; m_byte0 = 8'd0;
            m_act1 = 1'b0; m_pos1 = 0; m_fr1 = 8'd0; m_byte1 = 8'd0;
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            model_step(valid0, data0, 10, m_act0, m_pos0, m_byte0, m_fr0, acc);
            if (acc) exp_q0.push_back(data0);
            model_step(valid1, data1, 11, m_act1, m_pos1, m_byte1, m_fr1, acc);
            if (acc) exp_q1.push_back(data1);
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            check("tx0",     tx0,     m_act0 ? frame_bit(m_byte0, m_pos0 / N, 1'b0) : 1'b1);
            check("ready0",  ready0,  !m_act0);
            check("busy0",   busy0,   m_act0);
            check("frames0", frames0, m_fr0);
            check("tx1",     tx1,     m_act1 ? frame_bit(m_byte1, m_pos1 / N, 1'b1) : 1'b1);
            check("ready1",  ready1,  !m_act1);
            check("busy1",   busy1,   m_act1);
            check("frames1", frames1, m_fr1);
        end
    end

    // Driver: present a byte, let it be taken on the next edge
    task automatic start_frame(input int d, input logic [7:0] b, input bit hold);
        @(negedge clk);
        if (d == 0) begin valid0 = 1'b1; data0 = b; end
        else        begin valid1 = 1'b1; data1 = b; end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (d == 0) valid0 = 1'b0;
            else        valid1 = 1'b0;
        end
    endtask

    // Sample the line mid-bit for one whole frame, called just after the
    // accept edge; bits[0] is the start bit.
    task automatic capture(input int d, output logic [10:0] bits, output logic rdy_last);
        int   f;
        logic cells [0:43];
        logic [7:0] exp_b;
        f = (d == 0) ? 10 : 11;
        rdy_last = 1'b1;
        for (int k = 0; k < f * N; k++) begin
            @(negedge clk);
            cells[k] = (d == 0) ? tx0 : tx1;
            rdy_last = (d == 0) ? ready0 : ready1;
        end
        bits = '1;
        for (int j = 0; j < f; j++) bits[j] = cells[j * N + N / 2];
        if (d == 0 && exp_q0.size() > 0) begin
            exp_b = exp_q0.pop_front();
            check("sb_byte0", bits[8:1], exp_b);
        end else if (d == 1 && exp_q1.size() > 0) begin
            exp_b = exp_q1.pop_front();
            check("sb_byte1", bits[8:1], exp_b);
        end else begin
            check("sb_queue_empty", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_ready(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((d == 0 ? ready0 : ready1) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        logic [10:0] bits;
        logic        rl;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx0", tx0, 1'b1);
        check("rst_ready0", ready0, 1'b1);
        check("rst_busy0", busy0, 1'b0);
        check("rst_frames0", frames0, 8'd0);
        check("rst_state0", state0, 3'd0);
        check("rst_tx1", tx1, 1'b1);
        #1 rst = 1'b0;

        // Single frame 0xA5, no parity
        start_frame(0, 8'hA5, 1'b0);
        capture(0, bits, rl);
        check("a5_frame", bits[9:0], {1'b1, 8'hA5, 1'b0});
        check("a5_ready_edge39", rl, 1'b0);
        @(negedge clk);
        check("a5_ready_edge40", ready0, 1'b1);
        check("a5_frames", frames0, 8'd1);

        // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0
        start_frame(1, 8'h07, 1'b0);
        capture(1, bits, rl);
        check("p07_frame", bits, {1'b1, 1'b1, 8'h07, 1'b0});
        check("p07_ready_edge43", rl, 1'b0);
        @(negedge clk);
        check("p07_ready_edge44", ready1, 1'b1);
        start_frame(1, 8'h03, 1'b0);
        capture(1, bits, rl);
        check("p03_frame", bits, {1'b1, 1'b0, 8'h03, 1'b0});
        check("p03_ready_edge43", rl, 1'b0);
        @(negedge clk);
        check("p03_ready_edge44", ready1, 1'b1);
        check("p_frames", frames1, 8'd2);

        // Back-to-back with res_data churning during frame 1
        start_frame(0, 8'h01, 1'b1);
        fork
            capture(0, bits, rl);
            for (int k = 0; k < 10 * N; k++) begin
                @(negedge clk);
                data0 = 8'($urandom_range(0, 255));
            end
        join
        check("b2b_first", bits[9:0], {1'b1, 8'h01, 1'b0});
        @(negedge clk);
        data0 = 8'hFF;
        check("b2b_idle_tx", tx0, 1'b1);
        check("b2b_idle_ready", ready0, 1'b1);
        @(posedge clk);
        #1 valid0 = 1'b0;
        capture(0, bits, rl);
        check("b2b_second", bits[9:0], {1'b1, 8'hFF, 1'b0});
        @(negedge clk);
        check("b2b_frames", frames0, 8'd3);

        // Asynchronous reset during data bit 3 of 0x5A
        start_frame(0, 8'h5A, 1'b0);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx", tx0, 1'b1);
        check("mid_rst_ready", ready0, 1'b1);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_frames", frames0, 8'd0);
        check("mid_rst_state", state0, 3'd0);
        check("mid_rst_frames1", frames1, 8'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        start_frame(0, 8'h3C, 1'b0);
        capture(0, bits, rl);
        check("after_rst_frame", bits[9:0], {1'b1, 8'h3C, 1'b0});
        @(negedge clk);
        check("after_rst_frames", frames0, 8'd1);

        // frames_sent wrap over 256 frames from zero
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            start_frame(0, 8'(i), 1'b0);
            wait_ready(0);
            if (i == 254) check("wrap_255", frames0, 8'd255);
        end
        check("wrap_0", frames0, 8'd0);
        check("wrap_idle_tx", tx0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
